// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks FETCH/DECODE/EXEC/MEM/WB from the IR opcode and
// drives the shared memory port, PC/IR enables, ALU selects, writeback select and instret.
module multicycle_ctrl #(
   parameter int MEM_WAIT_MAX = 255,
   parameter int RET_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             timeout,
   output logic [RET_W-1:0] instret
);

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Counter only ever holds MEM_WAIT_MAX-1 before expiry moves us to HALT.
   localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t            cur_state, nxt_state;
   logic [WW-1:0]     wait_cnt;
   logic              wait_inc;
   logic              illegal_q, timeout_q;
   logic              set_illegal, set_timeout;
   logic              retire;
   logic [RET_W-1:0]  instret_q;

   logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui, legal;
   logic expire;

   logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_write_c, pc_write_c;
   logic [1:0] pc_src_c, alu_src_b_c, wb_sel_c;
   logic       alu_src_a_c, reg_write_c;
   logic       op_a;
   logic [1:0] op_b;

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_lui    = (opcode == OP_LUI);
   assign legal     = (opcode == OP_RTYPE) || (opcode == OP_ITYPE) || is_load || is_store ||
                      is_branch || is_lui || (opcode == OP_AUIPC) || is_jal || is_jalr;

   // Ready in the expiry cycle still completes the access normally.
   assign expire = (MEM_WAIT_MAX != 0) && !mem_ready &&
                   (wait_cnt == WW'(MEM_WAIT_MAX - 1));

   // ALU operand selects used in EXEC and held through WB.
   always_comb begin
      op_a = 1'b0;
      op_b = 2'b00;
      case (opcode)
         OP_ITYPE, OP_LOAD, OP_STORE, OP_JALR: op_b = 2'b01;
         OP_AUIPC: begin
            op_a = 1'b1;
            op_b = 2'b01;
         end
         OP_JAL: begin
            op_a = 1'b1;
            op_b = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= S_FETCH;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         instret_q <= '0;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_inc ? wait_cnt + 1'b1 : '0;
         if (set_illegal) illegal_q <= 1'b1;
         if (set_timeout) timeout_q <= 1'b1;
         if (retire)      instret_q <= instret_q + 1'b1;
      end
   end

   always_comb begin
      nxt_state      = cur_state;
      wait_inc       = 1'b0;
      set_illegal    = 1'b0;
      set_timeout    = 1'b0;
      retire         = 1'b0;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_sel_c = 1'b0;
      ir_write_c     = 1'b0;
      pc_write_c     = 1'b0;
      pc_src_c       = 2'b00;
      alu_src_a_c    = 1'b0;
      alu_src_b_c    = 2'b00;
      reg_write_c    = 1'b0;
      wb_sel_c       = 2'b00;
      case (cur_state)
         S_FETCH: begin
            mem_req_c  = 1'b1;
            ir_write_c = mem_ready;
            if (mem_ready) begin
               nxt_state = S_DECODE;
            end else if (expire) begin
               nxt_state   = S_HALT;
               set_timeout = 1'b1;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_DECODE: begin
            if (legal) begin
               nxt_state = S_EXEC;
            end else begin
               nxt_state   = S_HALT;
               set_illegal = 1'b1;
            end
         end
         S_EXEC: begin
            alu_src_a_c = op_a;
            alu_src_b_c = op_b;
            if (is_branch) begin
               pc_write_c = 1'b1;
               pc_src_c   = branch_taken ? 2'b01 : 2'b00;
               retire     = 1'b1;
               nxt_state  = S_FETCH;
            end else if (is_load || is_store) begin
               nxt_state = S_MEM;
            end else begin
               nxt_state = S_WB;
            end
         end
         S_MEM: begin
            mem_req_c      = 1'b1;
            mem_addr_sel_c = 1'b1;
            mem_we_c       = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  pc_write_c = 1'b1;
                  retire     = 1'b1;
                  nxt_state  = S_FETCH;
               end else begin
                  nxt_state = S_WB;
               end
            end else if (expire) begin
               nxt_state   = S_HALT;
               set_timeout = 1'b1;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_WB: begin
            alu_src_a_c = op_a;
            alu_src_b_c = op_b;
            reg_write_c = 1'b1;
            pc_write_c  = 1'b1;
            retire      = 1'b1;
            nxt_state   = S_FETCH;
            if (is_load)                  wb_sel_c = 2'b01;
            else if (is_jal || is_jalr)   wb_sel_c = 2'b10;
            else if (is_lui)              wb_sel_c = 2'b11;
            if (is_jal)                   pc_src_c = 2'b01;
            else if (is_jalr)             pc_src_c = 2'b10;
         end
         S_HALT: ;
         default: nxt_state = S_HALT;
      endcase
   end

   // Everything is forced low while reset is held so nothing escapes mid-abort.
   assign mem_req      = rst_n & mem_req_c;
   assign mem_we       = rst_n & mem_we_c;
   assign mem_addr_sel = rst_n & mem_addr_sel_c;
   assign ir_write     = rst_n & ir_write_c;
   assign pc_write     = rst_n & pc_write_c;
   assign pc_src       = rst_n ? pc_src_c : 2'b00;
   assign alu_src_a    = rst_n & alu_src_a_c;
   assign alu_src_b    = rst_n ? alu_src_b_c : 2'b00;
   assign reg_write    = rst_n & reg_write_c;
   assign wb_sel       = rst_n ? wb_sel_c : 2'b00;
   assign state        = cur_state;
   assign illegal      = illegal_q;
   assign timeout      = timeout_q;
   assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction stream with a memory responder,
// retirement scoreboard, plus directed watchdog, illegal-opcode and reset-abort cases.
module tb_multicycle_ctrl;

   localparam int EW = 23;
   localparam logic [6:0] RTYPE  = 7'b0110011;
   localparam logic [6:0] ITYPE  = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
   logic [1:0] pc_src, alu_src_b, wb_sel;
   logic       alu_src_a, reg_write;
   logic [2:0] state;
   logic       illegal, timeout;
   logic [3:0] instret;

   logic [EW-1:0] exp_q[$];
   int            wait_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            retire_cnt = 0;
   int            cyc = 0;
   logic [3:0]    exp_ret = '0;
   logic          mon_en = 1'b0;
   logic [6:0]    cur_op = '0;
   logic [6:0]    op_tab[9];

   multicycle_ctrl #(.MEM_WAIT_MAX(4), .RET_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .reg_write(reg_write), .wb_sel(wb_sel), .state(state), .illegal(illegal),
      .timeout(timeout), .instret(instret)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [EW-1:0] pack(input int lat, input logic [2:0] st,
      input logic [1:0] pcs, input logic [1:0] wbs, input logic rw, input logic a,
      input logic [1:0] b, input logic mreq, input logic mwe, input logic masel,
      input logic irw);
      return {lat[7:0], st, pcs, wbs, rw, a, b, mreq, mwe, masel, irw};
   endfunction

   // Reference: what the retiring cycle looks like for each instruction kind.
   function automatic logic [EW-1:0] model(input logic [6:0] op, input logic tk,
                                           input int fw, input int mw);
      int lat = 4 + fw;
      logic [2:0] st = 3'd4;
      logic [1:0] pcs = 2'b00, wbs = 2'b00, b = 2'b00;
      logic rw = 1'b1, a = 1'b0, mreq = 1'b0, mwe = 1'b0, masel = 1'b0;
      case (op)
         ITYPE:  b = 2'b01;
         LOAD:   begin b = 2'b01; wbs = 2'b01; lat = 5 + fw + mw; end
         STORE:  begin st = 3'd3; rw = 1'b0; mreq = 1'b1; mwe = 1'b1; masel = 1'b1; lat = 4 + fw + mw; end
         BRANCH: begin st = 3'd2; rw = 1'b0; pcs = tk ? 2'b01 : 2'b00; lat = 3 + fw; end
         LUI:    wbs = 2'b11;
         AUIPC:  begin a = 1'b1; b = 2'b01; end
         JAL:    begin a = 1'b1; b = 2'b10; pcs = 2'b01; wbs = 2'b10; end
         JALR:   begin b = 2'b01; pcs = 2'b10; wbs = 2'b10; end
         default: ;
      endcase
      return pack(lat, st, pcs, wbs, rw, a, b, mreq, mwe, masel, 1'b0);
   endfunction

   // ---------------- memory responder ----------------
   always @(negedge clk) begin
      if (rst_n && mem_req && wait_q.size() > 0) begin
         if (wait_q[0] == 0) begin
            mem_ready = 1'b1;
            void'(wait_q.pop_front());
         end else begin
            mem_ready = 1'b0;
            wait_q[0] = wait_q[0] - 1;
         end
      end else begin
         mem_ready = 1'b0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         cyc     = 0;
         exp_ret = '0;
      end else if (mon_en) begin
         cyc++;
         if (mem_req)
            check("mem_we_cycle", mem_we, mem_addr_sel ? (cur_op == STORE) : 1'b0);
         if (mem_req && !mem_addr_sel)
            check("ir_write_fetch", ir_write, mem_ready);
         if (pc_write) begin
            if (exp_q.size() == 0) begin
               check("unexpected_retire", 1, 0);
            end else begin
               check("retire_record",
                     pack(cyc, state, pc_src, wb_sel, reg_write, alu_src_a, alu_src_b,
                          mem_req, mem_we, mem_addr_sel, ir_write),
                     exp_q.pop_front());
            end
            check("instret", instret, exp_ret);
            exp_ret = exp_ret + 4'd1;
            cyc = 0;
            retire_cnt++;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_instr(input logic [6:0] op, input logic tk, input int fw, input int mw);
      int  start = retire_cnt;
      bit  got = 0;
      cur_op       = op;
      opcode       = op;
      branch_taken = tk;
      wait_q.push_back(fw);
      if (op == LOAD || op == STORE) wait_q.push_back(mw);
      exp_q.push_back(model(op, tk, fw, (op == LOAD || op == STORE) ? mw : 0));
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         #2;
         if (retire_cnt != start) got = 1;
      end
      if (!got) check("retire_wait", 0, 1);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      wait_q.delete();
      exp_q.delete();
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] st, output int n);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (state == st) return;
         n++;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int viol;
      op_tab = '{RTYPE, ITYPE, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR};
      rst_n = 1'b0;
      opcode = '0;
      branch_taken = 1'b0;
      mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_outputs",
            {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
             reg_write, wb_sel, state, illegal, timeout, instret}, 0);

      release_reset();
      mon_en = 1'b1;
      run_instr(ITYPE, 1'b0, 0, 0);
      run_instr(LOAD, 1'b0, 0, 3);
      run_instr(BRANCH, 1'b1, 0, 0);
      run_instr(BRANCH, 1'b0, 0, 0);
      run_instr(JALR, 1'b0, 0, 0);
      run_instr(STORE, 1'b0, 0, 2);
      run_instr(STORE, 1'b0, 3, 3);
      for (int k = 0; k < 40; k++)
         run_instr(op_tab[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));

      // Watchdog expiry in FETCH
      mon_en = 1'b0;
      wait_q.delete();
      wait_q.push_back(100);
      wait_state(3'd5, n);
      check("timeout_latency", n, 4);
      check("timeout_halt", {timeout, illegal, mem_req, state}, {1'b1, 1'b0, 1'b0, 3'd5});

      do_reset();
      check("reset_clears_timeout", {timeout, state, mem_req}, 0);
      opcode = 7'b0000000;
      cur_op = 7'b0000000;
      release_reset();
      wait_q.push_back(0);
      wait_state(3'd5, n);
      check("illegal_latency", n, 2);
      check("illegal_flags", {illegal, timeout}, 2'b10);
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         if ({mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
              reg_write, wb_sel} != 0 || state != 3'd5 || instret != 4'd0 || !illegal)
            viol++;
      end
      check("halt_quiet", viol, 0);

      do_reset();
      check("reset_clears_illegal", {illegal, state}, 0);
      release_reset();

      // Reset asserted while an instruction sits in EXEC
      mon_en = 1'b1;
      opcode = ITYPE;
      cur_op = ITYPE;
      wait_q.push_back(0);
      wait_state(3'd2, n);
      check("reach_exec", state, 3'd2);
      rst_n = 1'b0;
      #1;
      check("abort_in_exec", {pc_write, reg_write, state, instret}, 0);
      do_reset();
      release_reset();
      run_instr(ITYPE, 1'b0, 1, 0);
      run_instr(JAL, 1'b0, 0, 0);
      run_instr(LUI, 1'b0, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
